// File: rtl/iq_upconverter.sv
// rtl/iq_upconverter.sv - zero-order-hold I/Q upconverter mixing baseband symbols onto an NCO carrier
module iq_upconverter #(
  parameter int SPS = 8,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] q_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cos_in,
  input  logic [W-1:0] sin_in,
  output logic [W-1:0] s_out,
  output logic         out_valid,
  output logic         underrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic signed [W-1:0]  hold_i, hold_q, hold_i_nxt, hold_q_nxt;
  logic                 underrun_nxt;
  logic                 last, accept;

  logic signed [2*W-1:0] p_i, p_q;
  logic signed [2*W:0]   d;
  logic                  act1, act2;
  logic [W-1:0]          sat_val;

  assign last   = (cnt == CW'(SPS - 1));
  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_i_nxt   = hold_i;
    hold_q_nxt   = hold_q;
    underrun_nxt = 1'b0;
    in_ready     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (accept) begin
          hold_i_nxt = i_in;
          hold_q_nxt = q_in;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        in_ready = !reset && last;
        cnt_nxt  = cnt + 1'b1;
        if (last) begin
          cnt_nxt = '0;
          if (accept) begin
            hold_i_nxt = i_in;
            hold_q_nxt = q_in;
          end else begin
            // Starved: zeroed hold values keep the pipeline draining zeros.
            state_nxt    = IDLE;
            hold_i_nxt   = '0;
            hold_q_nxt   = '0;
            underrun_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_i   <= '0;
      hold_q   <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_i   <= hold_i_nxt;
      hold_q   <= hold_q_nxt;
      underrun <= underrun_nxt;
    end
  end

  // Keep the two guard bits above the Q1 output position; anything but all-equal overflows.
  always_comb begin
    sat_val = d[2*W-2:W-1];
    if (d[2*W:2*W-2] != 3'b000 && d[2*W:2*W-2] != 3'b111)
      sat_val = d[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_i       <= '0;
      p_q       <= '0;
      d         <= '0;
      s_out     <= '0;
      act1      <= 1'b0;
      act2      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      p_i       <= (2*W)'(hold_i) * (2*W)'($signed(cos_in));
      p_q       <= (2*W)'(hold_q) * (2*W)'($signed(sin_in));
      act1      <= (state == RUN);
      d         <= (2*W+1)'(p_i) - (2*W+1)'(p_q);
      act2      <= act1;
      s_out     <= sat_val;
      out_valid <= act2;
    end
  end

endmodule

// File: tb/tb_iq_upconverter.sv
// tb/tb_iq_upconverter.sv - scoreboard bench for iq_upconverter
module tb_iq_upconverter;

  localparam int SPS = 8;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_in, q_in, cos_in, sin_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s_out;
  logic         out_valid;
  logic         underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ur_cnt   = 0;
  int val_cnt  = 0;
  int run_len  = 0;
  int max_run  = 0;
  int xfers    = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  iq_upconverter #(.SPS(SPS), .W(W)) dut (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .cos_in(cos_in), .sin_in(sin_in),
    .s_out(s_out), .out_valid(out_valid), .underrun(underrun)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact real-valued mix, scaled back to Q1.15 with floor and clamp.
  function automatic logic [W-1:0] model(input logic [W-1:0] si, sq, c, s);
    longint full, sc;
    full = longint'($signed(si)) * longint'($signed(c)) - longint'($signed(sq)) * longint'($signed(s));
    sc = full >>> 15;
    if (sc > 32767) sc = 32767;
    if (sc < -32768) sc = -32768;
    return W'(sc);
  endfunction

  task automatic send(input logic [W-1:0] si, input logic [W-1:0] sq, input bit drop);
    int n;
    logic [W-1:0] e;
    i_in = si; q_in = sq; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 64) begin
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    e = model(si, sq, cos_in, sin_in);
    for (int k = 0; k < SPS; k++) exp_q.push_back(e);
    xfers++;
    #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic clear_stats();
    ur_cnt = 0; val_cnt = 0; max_run = 0; xfers = 0;
  endtask

  task automatic drain_and_check(input string tag, input int n_sym);
    repeat (SPS + 8) @(posedge clk);
    #1;
    check({tag, "_valid_count"}, val_cnt, n_sym * SPS);
    check({tag, "_underrun_count"}, ur_cnt, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (underrun) ur_cnt++;
    if (out_valid) begin
      val_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
      else check("s_out", s_out, exp_q.pop_front());
    end else begin
      run_len = 0;
      if (!reset) check("s_out_idle_zero", s_out, 0);
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    i_in = '0; q_in = '0; cos_in = '0; sin_in = '0;
    // Reset with random inputs present
    for (int k = 0; k < 4; k++) begin
      i_in = W'($urandom); q_in = W'($urandom);
      cos_in = W'($urandom); sin_in = W'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      check("rst_s_out", s_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_underrun", underrun, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    // Single in-phase symbol
    cos_in = 16'h4000; sin_in = 16'h0000;
    clear_stats();
    check("model_inphase", model(16'h4000, 16'h0000, cos_in, sin_in), 16'h2000);
    send(16'h4000, 16'h0000, 1'b1);
    drain_and_check("inphase", 1);

    // Quadrature branch
    cos_in = 16'h0000; sin_in = 16'h4000;
    clear_stats();
    send(16'h0000, 16'h4000, 1'b1);
    drain_and_check("quad", 1);

    // Positive and negative saturation
    cos_in = 16'h7FFF; sin_in = 16'h7FFF;
    clear_stats();
    send(16'h7FFF, 16'h8000, 1'b1);
    drain_and_check("sat_pos", 1);
    clear_stats();
    send(16'h8000, 16'h7FFF, 1'b1);
    drain_and_check("sat_neg", 1);

    // Back-to-back A, B, C with in_valid held high
    cos_in = 16'h5A82; sin_in = 16'hA57E;
    clear_stats();
    send(16'h2000, 16'h1000, 1'b0);
    send(16'hE000, 16'h3000, 1'b0);
    send(16'h1234, 16'hF000, 1'b1);
    drain_and_check("b2b", 3);
    check("b2b_transfers", xfers, 3);
    check("b2b_continuous", max_run, 3 * SPS);

    // Reset at cnt==3, then a clean burst
    cos_in = 16'h4000; sin_in = 16'h0000;
    clear_stats();
    send(16'h6000, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s_out", s_out, 0);
    @(posedge clk); #1;
    check("midrst_no_underrun", ur_cnt, 0);
    reset = 1'b0;
    clear_stats();
    cos_in = 16'h2000; sin_in = 16'h4000;
    send(16'h3000, 16'hD000, 1'b1);
    drain_and_check("post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
